wave_playback: RTL and testbench
================================

# wave_playback

Replays a recorded waveform onto an 8-bit signal: it accepts (timestamp, value) change records over a valid/ready stream, buffers them, and drives each value onto its output when a free-running cycle counter reaches the record's timestamp. It reads back the value-change traces our benches dump, and serves as a hardware stimulus source in place of hand-written `always`/`initial` stimulus. It sits between a trace loader (host or ROM) and the design under test.

## Interface
- DATA_W, 8: width of replayed value
- TS_W, 16: width of timestamps and cycle counter
- DEPTH, 4: record FIFO depth; power of 2, at least 2

- clk  in  1  sole clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  record present on in_time/in_value
- in_ready  out  1  FIFO can accept a record
- in_time  in  TS_W  cycle at which in_value is to be applied
- in_value  in  DATA_W  value to drive
- start  in  1  one-cycle pulse; begins playback
- stop  in  1  one-cycle pulse; aborts playback and flushes the FIFO
- out_value  out  DATA_W  replayed signal
- out_change  out  1  one-cycle pulse when out_value was just updated
- cycle  out  TS_W  playback cycle counter
- busy  out  1  high in RUN
- late_err  out  1  sticky; a record was applied after its timestamp

## Operation
- Reset values: out_value=0, out_change=0, cycle=0, busy=0, late_err=0, in_ready=1, FIFO empty, state IDLE.
- FIFO: a record is pushed when in_valid && in_ready. in_ready = !full, in both states. There is no pass-through: when full, in_ready stays low even if a pop occurs the same cycle. A push and a pop in the same cycle are both performed.
- IDLE: cycle holds its value. Records may be preloaded. start moves to RUN, sets cycle to 0 and clears late_err.
- RUN: cycle increments by 1 every clock and saturates at 2^TS_W-1; it does not wrap. Each cycle, if the FIFO is non-empty and head.time <= cycle:
  - pop the head, load out_value from it, and pulse out_change;
  - if head.time < cycle, also set late_err.
- At most one record is applied per cycle. Records with equal timestamps are applied on consecutive cycles. Every record after the first is late and sets late_err.
- Timestamps are expected to be non-decreasing. A decreasing timestamp is applied as late.
- stop in RUN: go to IDLE, flush the FIFO, and hold cycle and out_value. stop in IDLE flushes the FIFO.
- stop and start in the same cycle: stop wins, and start is ignored.
- start while in RUN is ignored.
- A FIFO that empties in RUN is not an error. The block stays in RUN and new records are applied when their timestamps come due.
- rst_n asserted mid-run returns every output to its reset value immediately (asynchronously) and discards buffered records.

## Timing
- start sampled high at edge E. cycle=0 and busy=1 are visible after E.
- Application latency is one cycle:
  - a record with time T, at the FIFO head while cycle==T, drives out_value and out_change=1 in the cycle where cycle==T+1;
  - out_change lasts exactly one cycle unless the next record is also due.
- A record pushed at edge E is eligible for popping from the cycle after E. Write-to-head latency is one cycle.
- late_err rises in the same cycle as the out_change of the late record.
- in_ready falls in the cycle after the push that fills the FIFO.

## Test plan
- Preload (2,0xA5), (5,0x3C), (5,0x11), then pulse start.
  - out_value=0xA5 at cycle 3; 0x3C at cycle 6; 0x11 at cycle 7.
  - late_err rises at cycle 7; out_change high at cycles 3, 6 and 7 only.
- With DEPTH=4, hold in_valid high with 5 records and no start. Exactly 4 are accepted, and in_ready stays low until playback pops one.
- Start with an empty FIFO, wait until cycle=20, then push (10,0x55).
  - out_value=0x55 two cycles after the push; late_err=1.
- Set TS_W=4, start, and run 20 cycles.
  - cycle saturates at 15, and a record (15,0x7E) is applied at saturation without error.
- Pulse start and stop together, then stop alone during RUN.
  - The combined pulse leaves the block in IDLE.
  - The lone stop flushes the FIFO, and out_value and cycle hold their values.
- Deassert rst_n while in RUN, with records pending and out_value=0x3C. Outputs go to reset values immediately, in_ready=1, and a following start produces no out_change.

Source files
------------

// File: rtl/wave_playback.sv
// Replays buffered (timestamp, value) records onto an 8-bit output as a free-running
// cycle counter reaches each record's timestamp; serves as a hardware stimulus source.
module wave_playback #(
    parameter int DATA_W = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TS_W-1:0]   in_time,
    input  logic [DATA_W-1:0] in_value,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] out_value,
    output logic              out_change,
    output logic [TS_W-1:0]   cycle,
    output logic              busy,
    output logic              late_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, RUN} state_e;
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] val;
    } rec_t;

    state_e            state_q, state_d;
    logic [TS_W-1:0]   cycle_q, cycle_d;
    logic [DATA_W-1:0] out_value_q, out_value_d;
    logic              out_change_q, out_change_d;
    logic              late_q, late_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    rec_t mem_q [DEPTH];
    rec_t head;
    logic full, empty, push;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = in_valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_time, in_value};
    end

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        out_value_d  = out_value_q;
        out_change_d = 1'b0;
        late_d       = late_q;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d     = rd_ptr_q;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else if (start) begin
                    state_d = RUN;
                    cycle_d = '0;
                    late_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    // Flush also discards a record offered in the same cycle.
                    state_d  = IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    if (cycle_q != {TS_W{1'b1}}) cycle_d = cycle_q + {{(TS_W-1){1'b0}}, 1'b1};
                    if (!empty && (head.ts <= cycle_q)) begin
                        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, 1'b1};
                        out_value_d  = head.val;
                        out_change_d = 1'b1;
                        if (head.ts < cycle_q) late_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            out_value_q  <= '0;
            out_change_q <= 1'b0;
            late_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            out_value_q  <= out_value_d;
            out_change_q <= out_change_d;
            late_q       <= late_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    assign in_ready   = !full;
    assign out_value  = out_value_q;
    assign out_change = out_change_q;
    assign cycle      = cycle_q;
    assign busy       = (state_q == RUN);
    assign late_err   = late_q;
endmodule

// File: tb/tb_wave_playback.sv
// Scoreboard bench for wave_playback: a queue-based reference model predicts every
// applied record; a negedge monitor compares DUT outputs against it.
module tb_wave_playback;
    localparam int DW    = 8;
    localparam int TW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXC  = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, in_ready, start = 1'b0, stop = 1'b0;
    logic [TW-1:0] in_time = '0, cycle;
    logic [DW-1:0] in_value = '0, out_value;
    logic          out_change, busy, late_err;

    logic          s_in_valid = 1'b0, s_in_ready, s_start = 1'b0, s_stop = 1'b0;
    logic [3:0]    s_in_time = '0, s_cycle;
    logic [DW-1:0] s_in_value = '0, s_out_value;
    logic          s_out_change, s_busy, s_late;

    wave_playback #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_time(in_time), .in_value(in_value), .start(start), .stop(stop),
        .out_value(out_value), .out_change(out_change), .cycle(cycle),
        .busy(busy), .late_err(late_err)
    );

    wave_playback #(.DATA_W(DW), .TS_W(4), .DEPTH(DEPTH)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_time(s_in_time), .in_value(s_in_value), .start(s_start), .stop(s_stop),
        .out_value(s_out_value), .out_change(s_out_change), .cycle(s_cycle),
        .busy(s_busy), .late_err(s_late)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: a record queue, a run flag and an integer cycle count.
    typedef struct {int t; int v;} mrec_t;
    typedef struct {int v; int c; bit l;} exp_t;
    mrec_t mq[$];
    exp_t  eq[$];
    bit    m_run;
    int    m_cyc;
    bit    m_late;
    int    m_val;

    always @(posedge clk or negedge rst_n) begin
        bit    acc;
        mrec_t r;
        if (!rst_n) begin
            mq.delete(); eq.delete();
            m_run = 0; m_cyc = 0; m_late = 0; m_val = 0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            if (!m_run) begin
                if (stop) mq.delete();
                else if (start) begin m_run = 1; m_cyc = 0; m_late = 0; end
            end else if (stop) begin
                m_run = 0;
                mq.delete();
            end else begin
                if (mq.size() > 0 && mq[0].t <= m_cyc) begin
                    r = mq.pop_front();
                    if (r.t < m_cyc) m_late = 1;
                    m_val = r.v;
                    eq.push_back('{r.v, (m_cyc < MAXC) ? m_cyc + 1 : MAXC, m_late});
                end
                if (m_cyc < MAXC) m_cyc++;
            end
            if (acc && !stop) mq.push_back('{int'(in_time), int'(in_value)});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_change) begin
                if (eq.size() == 0) chk("unexpected_change", out_change, 0);
                else begin
                    e = eq.pop_front();
                    chk("apply_value", out_value, e.v);
                    chk("apply_cycle", cycle, e.c);
                    chk("apply_late", late_err, e.l);
                end
            end else if (eq.size() > 0) begin
                chk("missed_change", out_change, 1);
                eq.delete();
            end
            chk("cycle", cycle, m_cyc);
            chk("busy", busy, m_run);
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("late_err", late_err, m_late);
            chk("out_value", out_value, m_val);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_rec(input int t, input int v);
        in_valid = 1'b1; in_time = TW'(t); in_value = DW'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse(input bit st, input bit sp);
        start = st; stop = sp;
        tick();
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_value", out_value, 0);
        chk("rst_cycle", cycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Example trace: equal timestamps land on consecutive cycles, second one late.
        push_rec(2, 8'hA5); push_rec(5, 8'h3C); push_rec(5, 8'h11);
        pulse(1, 0);
        chk("tp1_cycle0", cycle, 0);
        repeat (3) tick();
        chk("tp1_a5", out_value, 8'hA5);
        chk("tp1_chg3", out_change, 1);
        chk("tp1_late3", late_err, 0);
        repeat (3) tick();
        chk("tp1_3c", out_value, 8'h3C);
        chk("tp1_late6", late_err, 0);
        tick();
        chk("tp1_11", out_value, 8'h11);
        chk("tp1_late7", late_err, 1);
        tick();
        chk("tp1_chg8", out_change, 0);

        // Late arrival into an empty running FIFO.
        pulse(0, 1);
        pulse(1, 0);
        repeat (20) tick();
        chk("late_cyc20", cycle, 20);
        push_rec(10, 8'h55);
        tick();
        chk("late_value", out_value, 8'h55);
        chk("late_flag", late_err, 1);

        // Fill: five offered records, four accepted.
        pulse(0, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_time = TW'(i + 1); in_value = DW'(8'h20 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_ready", in_ready, 0);
        tick();
        chk("fill_ready_hold", in_ready, 0);
        pulse(1, 0);
        repeat (10) tick();
        chk("fill_last", out_value, 8'h23);

        // Saturation on a 4-bit counter.
        s_in_valid = 1'b1; s_in_time = 4'd15; s_in_value = 8'h7E;
        tick();
        s_in_valid = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (20) tick();
        chk("sat_cycle", s_cycle, 15);
        chk("sat_value", s_out_value, 8'h7E);
        chk("sat_late", s_late, 0);
        chk("sat_busy", s_busy, 1);

        // start+stop together, then lone stop mid-run.
        pulse(0, 1);
        pulse(1, 1);
        chk("ss_busy", busy, 0);
        push_rec(50, 1); push_rec(60, 2);
        pulse(1, 0);
        repeat (5) tick();
        pulse(0, 1);
        chk("stop_busy", busy, 0);
        chk("stop_cycle", cycle, 5);
        chk("stop_flush", in_ready, 1);
        chk("stop_value", out_value, 8'h23);
        repeat (3) tick();
        chk("stop_hold", cycle, 5);

        // Asynchronous reset mid-run.
        push_rec(1, 8'h3C); push_rec(100, 1); push_rec(200, 2);
        pulse(1, 0);
        repeat (3) tick();
        chk("pre_rst_value", out_value, 8'h3C);
        rst_n = 1'b0;
        #1;
        chk("arst_value", out_value, 0);
        chk("arst_change", out_change, 0);
        chk("arst_cycle", cycle, 0);
        chk("arst_busy", busy, 0);
        chk("arst_late", late_err, 0);
        chk("arst_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        tick();
        pulse(1, 0);
        repeat (5) tick();
        chk("post_rst_value", out_value, 0);
        chk("post_rst_change", out_change, 0);

        // Randomized traffic, mostly non-decreasing timestamps.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 9) == 0) in_time = TW'($urandom_range(0, m_cyc));
            else in_time = TW'(m_cyc + $urandom_range(0, 6));
            in_value = DW'($urandom);
            start = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 2);
            tick();
        end
        in_valid = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        chk("pending_expected", eq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
